// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seg7 scan driver.
// Segment codes are active-low, ordered a..g from bit 6 down to bit 0.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: combinational hex nibble to active-low segment decoder.
// Covers the full 0-F range.
module seg7_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed common-anode 7-segment driver.
// New values take effect only at frame boundaries.
module seg7_scan #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000,
  parameter int GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              off,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [NDIG-1:0]   in_blank,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);
  import seg7_pkg::*;

  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  scan_state_t      state, state_n;
  logic [DW-1:0]    digit, digit_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             pending, pending_n;
  logic [4*NDIG-1:0] act_data, act_data_n;
  logic [4*NDIG-1:0] pnd_data, pnd_data_n;
  logic [NDIG-1:0]  act_blank, act_blank_n;
  logic [NDIG-1:0]  pnd_blank, pnd_blank_n;
  logic             xfer, adv, lit;
  logic [3:0]       nib;
  logic [6:0]       hseg, seg_n;
  logic [NDIG-1:0]  an_n;

  assign in_ready = ~off & ~pending;
  assign xfer     = in_valid & in_ready;

  seg7_hex u_hex (
    .hex (nib),
    .seg (hseg)
  );

  // Next-state, pending handoff and next registered outputs.
  always_comb begin
    state_n     = state;
    digit_n     = digit;
    cnt_n       = cnt;
    gcnt_n      = gcnt;
    pending_n   = pending;
    act_data_n  = act_data;
    act_blank_n = act_blank;
    pnd_data_n  = pnd_data;
    pnd_blank_n = pnd_blank;
    adv         = 1'b0;
    if (off) begin
      state_n   = IDLE;
      digit_n   = '0;
      cnt_n     = '0;
      gcnt_n    = '0;
      pending_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            act_data_n  = in_data;
            act_blank_n = in_blank;
            state_n     = ON;
            digit_n     = '0;
            cnt_n       = '0;
          end
        end
        ON: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt_n = '0;
            if (GAP > 0) begin
              state_n = seg7_pkg::GAP;
              gcnt_n  = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        seg7_pkg::GAP: begin
          if (gcnt == GW'(GAP - 1)) begin
            gcnt_n  = '0;
            state_n = ON;
            adv     = 1'b1;
          end else begin
            gcnt_n = gcnt + GW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
      if (adv) begin
        if (digit == DW'(NDIG - 1)) begin
          digit_n = '0;
          if (pending) begin
            act_data_n  = pnd_data;
            act_blank_n = pnd_blank;
          end
          pending_n = 1'b0;
        end else begin
          digit_n = digit + DW'(1);
        end
      end
      if (xfer && state != IDLE) begin
        pnd_data_n  = in_data;
        pnd_blank_n = in_blank;
        pending_n   = 1'b1;
      end
    end
    nib   = act_data_n[{digit_n, 2'b00} +: 4];
    lit   = (state_n == ON) && !act_blank_n[digit_n];
    an_n  = lit ? ~(NDIG'(1) << digit_n) : '1;
    seg_n = lit ? hseg : SEG_OFF;
  end

  // State, data and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      digit     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      pending   <= 1'b0;
      act_data  <= '0;
      act_blank <= '1;
      pnd_data  <= '0;
      pnd_blank <= '1;
      an        <= '1;
      seg       <= SEG_OFF;
    end else begin
      state     <= state_n;
      digit     <= digit_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      pending   <= pending_n;
      act_data  <= act_data_n;
      act_blank <= act_blank_n;
      pnd_data  <= pnd_data_n;
      pnd_blank <= pnd_blank_n;
      an        <= an_n;
      seg       <= seg_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan, NDIG=4 DIV=4 GAP=1.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        off = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_blank = '0;
  logic [6:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t q[$];

  seg7_scan #(.NDIG(4), .DIV(4), .GAP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .off      (off),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_blank (in_blank),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || in_ready !== e.rdy) begin
          errors++;
          $display("FAIL %s: got an=%b seg=%b rdy=%b want an=%b seg=%b rdy=%b",
                   e.nm, an, seg, in_ready, e.an, e.seg, e.rdy);
        end
      end
    end
  end

  task automatic step(input logic [3:0] ea, input logic [6:0] es,
                      input logic er, input string nm);
    exp_t e;
    e.an  = ea;
    e.seg = es;
    e.rdy = er;
    e.nm  = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Expected outputs for frame positions first..first+n-1 (20 per frame).
  task automatic slots(input logic [15:0] d, input logic [3:0] b,
                       input int first, input int n,
                       input logic er, input string nm);
    for (int i = first; i < first + n; i++) begin
      int k;
      int dg;
      int c;
      logic [3:0] a;
      logic [6:0] s;
      logic [3:0] nb;
      k  = i % 20;
      dg = k / 5;
      c  = k % 5;
      a  = 4'hF;
      s  = 7'h7F;
      if (c < 4 && !b[dg]) begin
        a  = ~(4'b0001 << dg);
        nb = d[dg*4 +: 4];
        s  = HEX[nb];
      end
      step(a, s, er, nm);
    end
  endtask

  task automatic go_idle(input string nm);
    off = 1'b1;
    step(4'hF, 7'h7F, 1'b0, nm);
    off = 1'b0;
    step(4'hF, 7'h7F, 1'b1, nm);
  endtask

  task automatic start(input logic [15:0] d, input logic [3:0] b,
                       input string nm);
    in_data  = d;
    in_blank = b;
    in_valid = 1'b1;
    slots(d, b, 0, 1, 1'b1, nm);
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    step(4'hF, 7'h7F, 1'b1, "reset_held");
    step(4'hF, 7'h7F, 1'b1, "reset_held");
    rst = 1'b0;
    repeat (10) step(4'hF, 7'h7F, 1'b1, "reset_idle");

    start(16'h1234, 4'b0000, "scan");
    slots(16'h1234, 4'b0000, 1, 20, 1'b1, "scan");
    go_idle("scan_off");

    start(16'hABF0, 4'b0100, "blank");
    slots(16'hABF0, 4'b0100, 1, 19, 1'b1, "blank");
    go_idle("blank_off");

    start(16'hCDEB, 4'b0000, "hex2");
    slots(16'hCDEB, 4'b0000, 1, 19, 1'b1, "hex2");
    go_idle("hex2_off");

    start(16'h1111, 4'b0000, "tear");
    slots(16'h1111, 4'b0000, 1, 6, 1'b1, "tear");
    in_data  = 16'h2222;
    in_valid = 1'b1;
    slots(16'h1111, 4'b0000, 7, 1, 1'b0, "tear_xfer");
    in_valid = 1'b0;
    slots(16'h1111, 4'b0000, 8, 12, 1'b0, "tear_old");
    slots(16'h2222, 4'b0000, 0, 20, 1'b1, "tear_new");

    in_data  = 16'h5678;
    in_valid = 1'b1;
    slots(16'h2222, 4'b0000, 0, 1, 1'b0, "coll_edge");
    in_valid = 1'b0;
    slots(16'h2222, 4'b0000, 1, 19, 1'b0, "coll_old");
    slots(16'h5678, 4'b0000, 0, 10, 1'b1, "coll_new");

    in_data  = 16'h9999;
    in_valid = 1'b1;
    slots(16'h5678, 4'b0000, 10, 1, 1'b0, "offp_xfer");
    in_valid = 1'b0;
    slots(16'h5678, 4'b0000, 11, 1, 1'b0, "offp_hold");
    off = 1'b1;
    step(4'hF, 7'h7F, 1'b0, "offp_off");
    off = 1'b0;
    repeat (25) step(4'hF, 7'h7F, 1'b1, "offp_drop");

    start(16'h1239, 4'b0000, "arst");
    slots(16'h1239, 4'b0000, 1, 2, 1'b1, "arst");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      errors++;
      $display("FAIL arst_async: got an=%b seg=%b want an=1111 seg=1111111",
               an, seg);
    end
    @(negedge clk);
    step(4'hF, 7'h7F, 1'b1, "arst_held");
    rst = 1'b0;
    repeat (5) step(4'hF, 7'h7F, 1'b1, "arst_idle");

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
